// File: rtl/pipe_skid_latch.sv
// Purpose: two-entry pipeline latch (main + skid) between pipeline stages, carrying payload and control.
// Latency: 1 cycle from accept to out_*; in_ready depends only on registered state.
// Backpressure: a stall parks one extra entry in skid, then in_ready drops until the next drain.
module pipe_skid_latch #(
   parameter int DATA_W             = 16,
   parameter int CTRL_W             = 20,
   parameter int ZERO_DATA_ON_FLUSH = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [7:0]        stall_cnt
);

   // The valid bits are encoded in the state, so skid can never be valid without main.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   logic main_valid;
   logic skid_valid;
   logic accept;
   logic drain;
   logic ld_main_in;
   logic ld_main_skid;
   logic ld_skid;

   // Decode valid bits, handshakes and status outputs from registered state.
   always_comb begin
      main_valid = (state != ST_EMPTY);
      skid_valid = (state == ST_FULL);
      in_ready   = ~skid_valid;
      out_valid  = main_valid;
      accept     = in_valid & in_ready;
      drain      = main_valid & out_ready;
      occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
      out_data   = main_data;
      // A bubble must read as a NOP downstream even though main_ctrl keeps stale bits after a drain.
      out_ctrl   = main_valid ? main_ctrl : '0;
   end

   // Next state and register load enables.
   always_comb begin
      state_nxt    = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               ld_main_in = 1'b1;
               state_nxt  = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               ld_main_in = 1'b1;
            end else if (accept) begin
               ld_skid   = 1'b1;
               state_nxt = ST_FULL;
            end else if (drain) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a drain can move things.
            if (drain) begin
               ld_main_skid = 1'b1;
               state_nxt    = ST_ONE;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   // State register: reset beats flush, flush beats any handshake.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_EMPTY;
      end else if (flush) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Payload and control registers for main and skid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         main_ctrl <= '0;
         skid_ctrl <= '0;
         if (ZERO_DATA_ON_FLUSH != 0) begin
            main_data <= '0;
            skid_data <= '0;
         end
      end else begin
         if (ld_main_in) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
         end else if (ld_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
         end
         if (ld_skid) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
         end
      end
   end

   // Saturating count of cycles where a valid head is held back; flush does not touch it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt <= 8'd0;
      end else if (main_valid && !out_ready && (stall_cnt != 8'hFF)) begin
         stall_cnt <= stall_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_pipe_skid_latch.sv
module tb_pipe_skid_latch;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [19:0] in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [19:0] out_ctrl;
   logic [1:0]  occupancy;
   logic [7:0]  stall_cnt;

   logic        p_flush;
   logic        p_in_valid;
   logic        p_in_ready;
   logic [7:0]  p_in_data;
   logic [3:0]  p_in_ctrl;
   logic        p_out_valid;
   logic        p_out_ready;
   logic [7:0]  p_out_data;
   logic [3:0]  p_out_ctrl;
   logic [1:0]  p_occupancy;
   logic [7:0]  p_stall_cnt;

   int total;
   int bad;
   logic [35:0] exp_q[$];

   pipe_skid_latch dut (
      .clk(clk), .reset(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_skid_latch #(.DATA_W(8), .CTRL_W(4), .ZERO_DATA_ON_FLUSH(0)) dut_p (
      .clk(clk), .reset(rst), .flush(p_flush),
      .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data), .in_ctrl(p_in_ctrl),
      .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_ctrl(p_out_ctrl),
      .occupancy(p_occupancy), .stall_cnt(p_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Monitor: every downstream handshake pops the oldest expected entry.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", {16'h0, out_data}, 32'hDEAD);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e[35:20]));
            chk("out_ctrl", 32'(out_ctrl), 32'(e[19:0]));
         end
      end
   end

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
   task automatic tick(input logic iv, input logic [15:0] d, input logic [19:0] c,
                       input logic ordy, input logic fl, input logic exp_rdy);
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      if (iv) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (iv && exp_rdy && !fl) exp_q.push_back({d, c});
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_ctrl"},  32'(out_ctrl),  32'd0);
      chk({tag, "_out_data"},  32'(out_data),  32'd0);
      chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
      chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      p_flush = 1'b0; p_in_valid = 1'b0; p_in_data = '0; p_in_ctrl = '0; p_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      chk_reset_vals("rst0");

      // Streaming: each value visible one cycle after its accept.
      for (int i = 1; i <= 5; i++) begin
         tick(1'b1, 16'(i), 20'h00100 + 20'(i), 1'b1, 1'b0, 1'b1);
         chk("stream_data", 32'(out_data), 32'(i));
         chk("stream_occ", 32'(occupancy), 32'd1);
      end
      tick(1'b0, 16'h0, 20'h0, 1'b1, 1'b0, 1'b1);
      chk("stream_end_valid", 32'(out_valid), 32'd0);
      chk("bubble_ctrl", 32'(out_ctrl), 32'd0);

      // Backpressure: A then B fill both slots, C is refused until space opens.
      tick(1'b1, 16'h00AA, 20'h0A0A0, 1'b0, 1'b0, 1'b1);
      chk("bp_occ1", 32'(occupancy), 32'd1);
      tick(1'b1, 16'h00BB, 20'h0B0B0, 1'b0, 1'b0, 1'b1);
      chk("bp_occ2", 32'(occupancy), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick(1'b1, 16'h00CC, 20'h0C0C0, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_occ", 32'(occupancy), 32'd2);
      chk("bp_hold_data", 32'(out_data), 32'h00AA);
      chk("bp_stall", 32'(stall_cnt), 32'd2);
      tick(1'b1, 16'h00CC, 20'h0C0C0, 1'b1, 1'b0, 1'b0);
      chk("bp_after_drain_occ", 32'(occupancy), 32'd1);
      tick(1'b1, 16'h00CC, 20'h0C0C0, 1'b1, 1'b0, 1'b1);
      tick(1'b0, 16'h0, 20'h0, 1'b1, 1'b0, 1'b1);
      chk("bp_drained", 32'(occupancy), 32'd0);

      // Flush in FULL with an offer on the same cycle.
      tick(1'b1, 16'h0011, 20'hFFFFF, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 16'h0022, 20'hFFFFF, 1'b0, 1'b0, 1'b1);
      chk("fl_pre_occ", 32'(occupancy), 32'd2);
      tick(1'b1, 16'h0033, 20'hFFFFF, 1'b0, 1'b1, 1'b0);
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_ctrl", 32'(out_ctrl), 32'd0);
      chk("fl_occ", 32'(occupancy), 32'd0);
      chk("fl_in_ready", 32'(in_ready), 32'd1);
      chk("fl_data_zero", 32'(out_data), 32'd0);
      chk("fl_stall", 32'(stall_cnt), 32'd4);

      // Flush with simultaneous accept and drain: 0x44 leaves, 0x55 is dropped.
      tick(1'b1, 16'h0044, 20'h44444, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 16'h0055, 20'h55555, 1'b1, 1'b1, 1'b1);
      chk("fl2_occ", 32'(occupancy), 32'd0);
      tick(1'b0, 16'h0, 20'h0, 1'b1, 1'b0, 1'b1);
      chk("fl2_no_ghost", 32'(out_valid), 32'd0);

      // Stall saturation over 300 held cycles.
      tick(1'b1, 16'h0066, 20'h66666, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) tick(1'b0, 16'h0, 20'h0, 1'b0, 1'b0, 1'b1);
      chk("sat_cnt", 32'(stall_cnt), 32'd255);
      chk("hold_data", 32'(out_data), 32'h0066);
      chk("hold_ctrl", 32'(out_ctrl), 32'h66666);
      chk("hold_occ", 32'(occupancy), 32'd1);
      tick(1'b0, 16'h0, 20'h0, 1'b0, 1'b1, 1'b1);
      chk("sat_after_flush", 32'(stall_cnt), 32'd255);
      chk("sat_flush_occ", 32'(occupancy), 32'd0);

      // Reset in FULL with stall_cnt at 12.
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      chk("rst1_stall", 32'(stall_cnt), 32'd0);
      tick(1'b1, 16'h0077, 20'h77777, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 16'h0088, 20'h88888, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) tick(1'b0, 16'h0, 20'h0, 1'b0, 1'b0, 1'b1);
      // A reset glitch between edges must be ignored.
      #1 rst = 1'b0;
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("glitch_stall", 32'(stall_cnt), 32'd12);
      chk("glitch_occ", 32'(occupancy), 32'd2);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_data", 32'(out_data), 32'h0077);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      chk_reset_vals("rst2");

      // Parameter variant: payload survives flush, control and valid do not.
      p_in_valid = 1'b1; p_in_data = 8'h5A; p_in_ctrl = 4'hA;
      @(posedge clk);
      #1 p_in_valid = 1'b0;
      chk("p_valid", 32'(p_out_valid), 32'd1);
      chk("p_ctrl", 32'(p_out_ctrl), 32'hA);
      p_flush = 1'b1;
      @(posedge clk);
      #1 p_flush = 1'b0;
      chk("p_data_kept", 32'(p_out_data), 32'h5A);
      chk("p_ctrl_zero", 32'(p_out_ctrl), 32'd0);
      chk("p_valid_zero", 32'(p_out_valid), 32'd0);
      chk("p_occ", 32'(p_occupancy), 32'd0);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning payload width (operand values such as R_ra/R_rb concatenated).
REQ-002 The block SHALL have parameter CTRL_W, default 20, meaning control-bundle width (RW, SP, MW, ALU, BU and similar fields concatenated).
REQ-003 The block SHALL have parameter ZERO_DATA_ON_FLUSH, default 1, meaning 1 clears payload on flush and 0 leaves payload unchanged.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled only on the rising clk edge.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous kill of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream entry present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: block can accept an entry this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 The block SHALL have port in_ctrl, input, CTRL_W bits: upstream control bundle.
REQ-011 The block SHALL have port out_valid, output, 1 bit: downstream entry present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-013 The block SHALL have port out_data, output, DATA_W bits: head payload.
REQ-014 The block SHALL have port out_ctrl, output, CTRL_W bits: head control bundle.
REQ-015 The block SHALL have port occupancy, output, 2 bits: number of held entries, 0 to 2.
REQ-016 The block SHALL have port stall_cnt, output, 8 bits: saturating count of downstream stall cycles.

Function
REQ-017 The block SHALL hold two entries, main (drives out_*) and skid, each with a valid bit, payload and control.
REQ-018 The state SHALL be one of EMPTY (no valid entries), ONE (main valid only) or FULL (main and skid valid); the skid entry SHALL never be valid while main is invalid.
REQ-019 in_ready SHALL equal NOT skid_valid, decoded from registered state only and never combinationally from out_ready.
REQ-020 An accept SHALL occur when in_valid and in_ready are both 1; a drain SHALL occur when out_valid and out_ready are both 1.
REQ-021 In EMPTY, an accept SHALL load main, with the entry appearing on out_* the next cycle (latency 1), and the state SHALL go to ONE.
REQ-022 In ONE: accept with drain SHALL load main and stay in ONE; accept without drain SHALL load skid and go to FULL; drain without accept SHALL go to EMPTY; otherwise the state SHALL hold.
REQ-023 In FULL, a drain SHALL move skid into main and go to ONE, and no accept is possible in FULL.
REQ-024 Entries SHALL leave in acceptance order, with none lost or duplicated.
REQ-025 out_valid SHALL equal main_valid, and out_ctrl SHALL be all-zero whenever out_valid is 0 (a bubble reads as a NOP).
REQ-026 occupancy SHALL equal main_valid plus skid_valid.
REQ-027 A flush of 1 SHALL clear both valid bits and both control registers the next cycle, and SHALL also clear payload when ZERO_DATA_ON_FLUSH is 1.
REQ-028 flush SHALL take priority over a simultaneous accept and drain: the accepted entry is discarded and the drain handshake still completes downstream that cycle.
REQ-029 stall_cnt SHALL increment by 1 in each cycle where out_valid is 1 and out_ready is 0, saturate at 255, and be unaffected by flush.
REQ-030 Holding state with in_valid at 0 and out_ready at 0 SHALL leave all registers unchanged.

Reset
REQ-031 When reset is 0 at a rising clk edge, all valid bits, payload, control and stall_cnt SHALL become 0, and reset SHALL take priority over flush, accept and drain.
REQ-032 After reset the outputs SHALL be out_valid 0, out_ctrl 0, out_data 0, occupancy 0, stall_cnt 0 and in_ready 1.
REQ-033 A reset asserted in FULL or ONE SHALL discard all held entries with no partial drain.
REQ-034 There SHALL be no asynchronous reset path, so a reset pulse between clk edges has no effect.

Verification
REQ-035 Streaming case: with out_ready at 1 and in_valid at 1 for data 0x0001..0x0005, out_data SHALL show 0x0001..0x0005 on consecutive cycles, each 1 cycle after its accept, with occupancy 1 throughout.
REQ-036 Backpressure case: accept A=0x00AA, hold out_ready at 0, then offer B=0x00BB.
  - B SHALL be accepted and occupancy SHALL become 2.
  - in_ready SHALL then go to 0, and offer C SHALL not be accepted.
  - After out_ready goes to 1, the outputs SHALL be A, then B, then C, in order.
REQ-037 Flush-in-FULL case: with occupancy 2 and ctrl 0xFFFFF, pulse flush together with in_valid.
  - The next cycle SHALL show out_valid 0, out_ctrl 0, occupancy 0 and in_ready 1.
  - The concurrently offered entry SHALL never appear.
REQ-038 Stall-counter case: hold out_valid at 1 with out_ready at 0 for 300 cycles; stall_cnt SHALL read 255, and a following flush SHALL leave it at 255.
REQ-039 Reset-mid-operation case: in FULL with stall_cnt 12, drive reset to 0 for one edge; all outputs SHALL equal the REQ-032 values the next cycle, with no output corruption between edges.
REQ-040 Parameter case: with DATA_W 8, CTRL_W 4 and ZERO_DATA_ON_FLUSH 0, a flush SHALL leave out_data at its prior value of 0x5A while out_ctrl goes to 0 and out_valid goes to 0.
